mac_bist_controller: RTL and testbench

MAC_BIST_CONTROLLER -- requirements
Module: mac_bist_controller

---
 rtl/mac_bist_pkg.sv | 30 +++
 rtl/mac_bist_scoreboard.sv | 55 +++++
 rtl/mac_bist_controller.sv | 153 +++++++++++++++
 tb/tb_mac_bist_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_bist_pkg.sv
// ============================================================================
// Module      : mac_bist_pkg
// Description : Shared types and default widths for the MAC BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_bist_pkg;

  // Default datapath widths and pattern count
  localparam int DEF_A_WIDTH      = 8;
  localparam int DEF_W_WIDTH      = 8;
  localparam int DEF_P_WIDTH      = 32;
  localparam int DEF_NUM_PATTERNS = 16;

  // Down-counter width for the WAIT state; holds latencies up to 15
  localparam int WAIT_CNT_WIDTH   = 4;

  // Controller state encoding
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } bist_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_bist_scoreboard.sv
// ============================================================================
// Module      : mac_bist_scoreboard
// Description : Result comparison, saturating mismatch counter and capture of
//               the first failing pattern address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_bist_scoreboard
  import mac_bist_pkg::*;
#(
  parameter int P_WIDTH    = DEF_P_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  compare_en,
  input  logic [P_WIDTH-1:0]    result,
  input  logic [P_WIDTH-1:0]    expected,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  // Full-width signed equality check, only meaningful while comparing
  always_comb begin
    mismatch = compare_en && ($signed(result) != $signed(expected));
  end

  // Count mismatches (saturating) and remember where the first one happened
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_count      <= '0;
      first_fail_addr <= '0;
    end else if (clear) begin
      fail_count      <= '0;
      first_fail_addr <= '0;
    end else if (mismatch) begin
      if (fail_count != CNT_MAX) begin
        fail_count <= fail_count + CNT_ONE;
      end
      if (fail_count == '0) begin
        first_fail_addr <= addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_bist_controller.sv
// ============================================================================
// Module      : mac_bist_controller
// Description : Built-in self test sequencer for a MAC unit. Walks pattern ROM
//               addresses 1..NUM_PATTERNS-1, drives the MAC, waits its
//               latency and checks each result against the golden value.
//               Optional build macro BIST_STOP_ON_FAIL_EN ends the pass at
//               the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_bist_controller
  import mac_bist_pkg::*;
#(
  parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
  parameter int ADDR_WIDTH   = $clog2(NUM_PATTERNS),
  parameter int A_WIDTH      = DEF_A_WIDTH,
  parameter int W_WIDTH      = DEF_W_WIDTH,
  parameter int P_WIDTH      = DEF_P_WIDTH,
  parameter int MAC_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [A_WIDTH-1:0]    rom_a,
  input  logic [W_WIDTH-1:0]    rom_w,
  input  logic [P_WIDTH-1:0]    rom_p,
  input  logic [P_WIDTH-1:0]    rom_expected,
  output logic [A_WIDTH-1:0]    mac_a,
  output logic [W_WIDTH-1:0]    mac_w,
  output logic [P_WIDTH-1:0]    mac_p,
  output logic                  mac_valid,
  input  logic [P_WIDTH-1:0]    mac_result,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR = ADDR_WIDTH'(NUM_PATTERNS - 1);
  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(MAC_LATENCY);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE  = WAIT_CNT_WIDTH'(1);

  bist_state_t               state;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic [P_WIDTH-1:0]        expected_q;
  logic [P_WIDTH-1:0]        result_q;
  logic                      start_ok;
  logic                      compare_en;
  logic                      mismatch;

  // A start request is honoured only when no pass is running
  always_comb begin
    start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    compare_en = (state == S_COMPARE);
  end

  mac_bist_scoreboard #(
    .P_WIDTH    (P_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .clear           (start_ok),
    .compare_en      (compare_en),
    .result          (result_q),
    .expected        (expected_q),
    .addr            (rom_addr),
    .mismatch        (mismatch),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr)
  );

  // Sequencer: pattern walk, operand/expected capture and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      mac_a      <= '0;
      mac_w      <= '0;
      mac_p      <= '0;
      mac_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      wait_cnt   <= '0;
      expected_q <= '0;
      result_q   <= '0;
    end else begin
      mac_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            // Address 0 is the ROM's all-zero default and is skipped
            rom_addr <= ADDR_ONE;
            done     <= 1'b0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          mac_a      <= rom_a;
          mac_w      <= rom_w;
          mac_p      <= rom_p;
          expected_q <= rom_expected;
          mac_valid  <= 1'b1;
          wait_cnt   <= WAIT_LOAD;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_ONE) begin
            result_q <= mac_result;
            wait_cnt <= '0;
            state    <= S_COMPARE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_ONE;
          end
        end
        S_COMPARE: begin
`ifdef BIST_STOP_ON_FAIL_EN
          if (mismatch) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
            state <= S_DONE;
          end else
`endif
          if (rom_addr == LAST_ADDR) begin
            // The scoreboard updates on this same edge, so fold in mismatch
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == '0) && !mismatch;
            state <= S_DONE;
          end else begin
            rom_addr <= rom_addr + ADDR_ONE;
            state    <= S_APPLY;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_bist_controller.sv
// ============================================================================
// Module      : tb_mac_bist_controller
// Description : Directed self-checking bench for mac_bist_controller with a
//               pattern ROM and a latency-2 MAC model with fault injection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_bist_controller;

  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [AW-1:0]        rom_addr;
  logic signed [7:0]    rom_a;
  logic signed [7:0]    rom_w;
  logic signed [31:0]   rom_p;
  logic signed [31:0]   rom_expected;
  logic signed [7:0]    mac_a;
  logic signed [7:0]    mac_w;
  logic signed [31:0]   mac_p;
  logic                 mac_valid;
  logic signed [31:0]   mac_result = '0;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [AW-1:0]        fail_count;
  logic [AW-1:0]        first_fail_addr;

  logic [15:0]          fault_mask = '0;
  int                   total = 0;
  int                   bad = 0;
  int                   rom_ai, rom_wi, rom_pi;

  mac_bist_controller dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .rom_addr        (rom_addr),
    .rom_a           (rom_a),
    .rom_w           (rom_w),
    .rom_p           (rom_p),
    .rom_expected    (rom_expected),
    .mac_a           (mac_a),
    .mac_w           (mac_w),
    .mac_p           (mac_p),
    .mac_valid       (mac_valid),
    .mac_result      (mac_result),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr)
  );

  always #5 clk = ~clk;

  // Pattern ROM: odd a=+addr,w=10; even a=-addr,w=7; p=40*addr; golden a*w+p
  // (address 3 gives 3*10+120 = 150)
  always_comb begin
    rom_ai = 0;
    rom_wi = 0;
    rom_pi = 0;
    if (rom_addr != '0) begin
      rom_ai = rom_addr[0] ? int'(rom_addr) : -int'(rom_addr);
      rom_wi = rom_addr[0] ? 10 : 7;
      rom_pi = 40 * int'(rom_addr);
    end
    rom_a        = 8'(rom_ai);
    rom_w        = 8'(rom_wi);
    rom_p        = 32'(rom_pi);
    rom_expected = 32'(rom_ai * rom_wi + rom_pi);
  end

  // MAC model: result available MAC_LATENCY=2 edges after the APPLY->WAIT edge
  always @(posedge clk) begin
    if (mac_valid) begin
      mac_result <= 32'(int'(mac_a) * int'(mac_w) + int'(mac_p)
                        + (fault_mask[rom_addr] ? 1 : 0));
    end
  end

  task automatic run_pass(output int cycles);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cycles = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rom_addr, mac_a, mac_w, mac_p, mac_valid, busy, done, pass, fail_count, first_fail_addr} !== '0) begin
      bad++;
      $display("FAIL reset_state: got addr=%0d busy=%b done=%b pass=%b fc=%0d ffa=%0d valid=%b mac_a=%0d, need all 0",
               rom_addr, busy, done, pass, fail_count, first_fail_addr, mac_valid, mac_a);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_all_pass;
    int cyc;
    fault_mask = '0;
    run_pass(cyc);
    total++;
    if (cyc !== 60) begin bad++; $display("FAIL all_pass_cycles: got %0d need 60", cyc); end
    total++;
    if ({pass, fail_count, first_fail_addr, busy} !== {1'b1, 4'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL all_pass_status: got pass=%b fc=%0d ffa=%0d busy=%b need 1/0/0/0", pass, fail_count, first_fail_addr, busy);
    end
    total++;
    if (mac_p !== 32'sd600 || mac_a !== 8'sd15) begin
      bad++;
      $display("FAIL all_pass_operands_held: got a=%0d p=%0d need 15/600", mac_a, mac_p);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      bad++;
      $display("FAIL done_held: got done=%b pass=%b need 1/1", done, pass);
    end
  endtask

  task automatic test_single_fault;
    int cyc;
    fault_mask = 16'h0008;
    run_pass(cyc);
    fault_mask = '0;
`ifdef BIST_STOP_ON_FAIL_EN
    total++;
    if (cyc !== 12) begin bad++; $display("FAIL single_fault_cycles: got %0d need 12", cyc); end
`else
    total++;
    if (cyc !== 60) begin bad++; $display("FAIL single_fault_cycles: got %0d need 60", cyc); end
`endif
    total++;
    if ({pass, fail_count, first_fail_addr} !== {1'b0, 4'd1, 4'd3}) begin
      bad++;
      $display("FAIL single_fault_status: got pass=%b fc=%0d ffa=%0d need 0/1/3", pass, fail_count, first_fail_addr);
    end
  endtask

  task automatic test_multi_fault;
    int cyc;
    fault_mask = 16'h0014;
    run_pass(cyc);
    fault_mask = '0;
`ifdef BIST_STOP_ON_FAIL_EN
    total++;
    if (cyc !== 8) begin bad++; $display("FAIL stop_on_fail_cycles: got %0d need 8", cyc); end
    total++;
    if ({pass, fail_count, first_fail_addr, rom_addr} !== {1'b0, 4'd1, 4'd2, 4'd2}) begin
      bad++;
      $display("FAIL stop_on_fail_status: got pass=%b fc=%0d ffa=%0d addr=%0d need 0/1/2/2",
               pass, fail_count, first_fail_addr, rom_addr);
    end
`else
    total++;
    if (cyc !== 60) begin bad++; $display("FAIL multi_fault_cycles: got %0d need 60", cyc); end
    total++;
    if ({pass, fail_count, first_fail_addr} !== {1'b0, 4'd2, 4'd2}) begin
      bad++;
      $display("FAIL multi_fault_status: got pass=%b fc=%0d ffa=%0d need 0/2/2", pass, fail_count, first_fail_addr);
    end
`endif
  endtask

  task automatic test_all_fault;
    int cyc;
    fault_mask = 16'hFFFE;
    run_pass(cyc);
    fault_mask = '0;
`ifdef BIST_STOP_ON_FAIL_EN
    total++;
    if ({cyc == 4, pass, fail_count, first_fail_addr} !== {1'b1, 1'b0, 4'd1, 4'd1}) begin
      bad++;
      $display("FAIL all_fault_status: got cyc=%0d pass=%b fc=%0d ffa=%0d need 4/0/1/1", cyc, pass, fail_count, first_fail_addr);
    end
`else
    total++;
    if ({cyc == 60, pass, fail_count, first_fail_addr} !== {1'b1, 1'b0, 4'd15, 4'd1}) begin
      bad++;
      $display("FAIL all_fault_status: got cyc=%0d pass=%b fc=%0d ffa=%0d need 60/0/15/1", cyc, pass, fail_count, first_fail_addr);
    end
`endif
  endtask

  task automatic test_reset_mid_pass;
    int cyc;
    bit hit;
    fault_mask = 16'h0002;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total++;
    if (rom_addr !== 4'd1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_state: got addr=%0d busy=%b done=%b need 1/1/0", rom_addr, busy, done);
    end
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (rom_addr == 4'd4 && mac_valid) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (hit !== 1'b1) begin bad++; $display("FAIL reach_addr4_wait: got 0 need 1"); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rom_addr, mac_a, mac_w, mac_p, mac_valid, busy, done, pass, fail_count, first_fail_addr} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got addr=%0d busy=%b fc=%0d ffa=%0d valid=%b mac_p=%0d need all 0",
               rom_addr, busy, fail_count, first_fail_addr, mac_valid, mac_p);
    end
    @(negedge clk) rst = 1'b0;
    fault_mask = '0;
    run_pass(cyc);
    total++;
    if ({cyc == 60, pass, fail_count, first_fail_addr} !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL rerun_after_reset: got cyc=%0d pass=%b fc=%0d ffa=%0d need 60/1/0/0", cyc, pass, fail_count, first_fail_addr);
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    bit pulsed;
    fault_mask = '0;
    pulsed = 1'b0;
    cyc = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        cyc = n;
        break;
      end
      if (!pulsed && rom_addr == 4'd2) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end
    start = 1'b0;
    total++;
    if (cyc !== 60) begin bad++; $display("FAIL start_busy_cycles: got %0d need 60", cyc); end
    total++;
    if ({pass, fail_count, rom_addr} !== {1'b1, 4'd0, 4'd15}) begin
      bad++;
      $display("FAIL start_busy_status: got pass=%b fc=%0d addr=%0d need 1/0/15", pass, fail_count, rom_addr);
    end
  endtask

  initial begin
    test_reset;
    test_all_pass;
    test_single_fault;
    test_multi_fault;
    test_all_fault;
    test_reset_mid_pass;
    test_start_while_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
